// File: rtl/kfpc_bus_pkg.sv
// Shared bus constants for the KFPC channel-ready logic: FSM state encoding,
// wait-counter width, default I/O and memory decode windows, and window-hit helpers.
package kfpc_bus_pkg;

    localparam int unsigned ADDR_W    = 20;
    localparam int unsigned IO_ADDR_W = 16;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned STATE_W   = 2;

    // FSM state encoding
    localparam logic [STATE_W-1:0] ST_IDLE = 2'b00;
    localparam logic [STATE_W-1:0] ST_WAIT = 2'b01;
    localparam logic [STATE_W-1:0] ST_HOLD = 2'b10;

    // Default decode windows and wait counts
    localparam logic [IO_ADDR_W-1:0] IO_BASE_DFLT   = 16'h0300;
    localparam logic [IO_ADDR_W-1:0] IO_MASK_DFLT   = 16'hFFF0;
    localparam logic [CNT_W-1:0]     IO_WAITS_DFLT  = 4'd2;
    localparam logic [ADDR_W-1:0]    MEM_BASE_DFLT  = 20'hC0000;
    localparam logic [ADDR_W-1:0]    MEM_MASK_DFLT  = 20'hF0000;
    localparam logic [CNT_W-1:0]     MEM_WAITS_DFLT = 4'd1;

    // Masked compare of a 16-bit I/O address against a window
    function automatic logic io_window_hit(
        input logic [IO_ADDR_W-1:0] addr,
        input logic [IO_ADDR_W-1:0] base,
        input logic [IO_ADDR_W-1:0] mask
    );
        return (addr & mask) == (base & mask);
    endfunction

    // Masked compare of a 20-bit memory address against a window
    function automatic logic mem_window_hit(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] mask
    );
        return (addr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/cpu_clock_edge_detect.sv
// Edge detector for the CPU bus clock level, which is synchronous to clock.
// Ports:
//   clock, reset            system clock, async active-high reset
//   cpu_clock_i             CPU bus clock level
//   cpu_clock_posedge_c_o   high for one clock after a 0->1 transition (combinational)
//   cpu_clock_negedge_c_o   high for one clock after a 1->0 transition (combinational)
module cpu_clock_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic cpu_clock_i,
    output logic cpu_clock_posedge_c_o,
    output logic cpu_clock_negedge_c_o
);

    logic prev_cpu_clock_q;

    // Previous cpu_clock level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_cpu_clock_q <= 1'b0;
        end else begin
            prev_cpu_clock_q <= cpu_clock_i;
        end
    end

    assign cpu_clock_posedge_c_o = ~prev_cpu_clock_q & cpu_clock_i;
    assign cpu_clock_negedge_c_o = prev_cpu_clock_q & ~cpu_clock_i;

endmodule

// File: rtl/io_channel_ready_gen.sv
// I/O channel ready generator: on the leading edge of a CPU-owned bus command
// that hits the I/O or memory decode window, pulls io_channel_ready low for a
// programmed number of cpu_clock rising edges, then holds until the command ends.
// Ports:
//   clock, reset                      system clock, async active-high reset
//   cpu_clock                         CPU bus clock level (sampled for edges)
//   address[19:0]                     bus address
//   io_read_n, io_write_n             active-low I/O commands
//   memory_read_n, memory_write_n     active-low memory commands
//   address_enable_n                  low = CPU cycle, high = DMA cycle
//   io_channel_ready                  registered; low exactly while waiting
//   wait_active                       registered; complement of io_channel_ready
module io_channel_ready_gen
    import kfpc_bus_pkg::*;
#(
    parameter logic [IO_ADDR_W-1:0] IO_BASE   = IO_BASE_DFLT,
    parameter logic [IO_ADDR_W-1:0] IO_MASK   = IO_MASK_DFLT,
    parameter logic [CNT_W-1:0]     IO_WAITS  = IO_WAITS_DFLT,
    parameter logic [ADDR_W-1:0]    MEM_BASE  = MEM_BASE_DFLT,
    parameter logic [ADDR_W-1:0]    MEM_MASK  = MEM_MASK_DFLT,
    parameter logic [CNT_W-1:0]     MEM_WAITS = MEM_WAITS_DFLT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_clock,
    input  logic [ADDR_W-1:0] address,
    input  logic              io_read_n,
    input  logic              io_write_n,
    input  logic              memory_read_n,
    input  logic              memory_write_n,
    input  logic              address_enable_n,
    output logic              io_channel_ready,
    output logic              wait_active
);

    logic               cpu_clock_posedge_c;
    logic               unused_cpu_clock_negedge;
    logic               command_c;
    logic               io_cmd_c;
    logic               mem_cmd_c;
    logic               start_c;
    logic               io_hit_c;
    logic               mem_hit_c;
    logic [CNT_W-1:0]   waits_c;
    logic               prev_command_q;
    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               wait_active_q;

    cpu_clock_edge_detect u_cpu_clock_edge_detect (
        .clock                 (clock),
        .reset                 (reset),
        .cpu_clock_i           (cpu_clock),
        .cpu_clock_posedge_c_o (cpu_clock_posedge_c),
        .cpu_clock_negedge_c_o (unused_cpu_clock_negedge)
    );

    // Command decode and leading-edge start; DMA cycles never start a wait
    assign io_cmd_c  = ~io_read_n | ~io_write_n;
    assign mem_cmd_c = ~memory_read_n | ~memory_write_n;
    assign command_c = io_cmd_c | mem_cmd_c;
    assign start_c   = ~prev_command_q & command_c & ~address_enable_n;

    assign io_hit_c  = io_window_hit(address[IO_ADDR_W-1:0], IO_BASE, IO_MASK);
    assign mem_hit_c = mem_window_hit(address, MEM_BASE, MEM_MASK);

    // Wait count select; an I/O hit takes priority over a memory hit
    always_comb begin
        waits_c = '0;
        if (io_cmd_c && io_hit_c) begin
            waits_c = IO_WAITS;
        end else if (mem_cmd_c && mem_hit_c) begin
            waits_c = MEM_WAITS;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    if (waits_c != '0) begin
                        state_d = ST_WAIT;
                        cnt_d   = waits_c;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_WAIT: begin
                // Abort beats the counter
                if (!command_c) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cpu_clock_posedge_c) begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (!command_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Ready follows the next state so it is low exactly while in WAIT
    assign ready_d = (state_d != ST_WAIT);

    // State, counter, command history and outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            prev_command_q <= 1'b1;
            ready_q        <= 1'b1;
            wait_active_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            prev_command_q <= command_c;
            ready_q        <= ready_d;
            wait_active_q  <= ~ready_d;
        end
    end

    assign io_channel_ready = ready_q;
    assign wait_active      = wait_active_q;

endmodule

// File: tb/tb_io_channel_ready_gen.sv
// Directed bench for io_channel_ready_gen: three instances (default, IO_WAITS=15,
// IO_WAITS=0) share one stimulus; a transaction-level model is compared every cycle.
module tb_io_channel_ready_gen;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_clock = 1'b0;
    logic [19:0] address = 20'h0;
    logic        io_read_n = 1'b1;
    logic        io_write_n = 1'b1;
    logic        memory_read_n = 1'b1;
    logic        memory_write_n = 1'b1;
    logic        address_enable_n = 1'b0;
    logic [2:0]  rdy;
    logic [2:0]  wact;

    int n_vec = 0;
    int n_err = 0;
    bit run_chk = 1'b0;

    always #5 clock = ~clock;

    io_channel_ready_gen u_a (
        .clock(clock), .reset(reset), .cpu_clock(cpu_clock), .address(address),
        .io_read_n(io_read_n), .io_write_n(io_write_n),
        .memory_read_n(memory_read_n), .memory_write_n(memory_write_n),
        .address_enable_n(address_enable_n),
        .io_channel_ready(rdy[0]), .wait_active(wact[0])
    );

    io_channel_ready_gen #(.IO_WAITS(4'd15)) u_b (
        .clock(clock), .reset(reset), .cpu_clock(cpu_clock), .address(address),
        .io_read_n(io_read_n), .io_write_n(io_write_n),
        .memory_read_n(memory_read_n), .memory_write_n(memory_write_n),
        .address_enable_n(address_enable_n),
        .io_channel_ready(rdy[1]), .wait_active(wact[1])
    );

    io_channel_ready_gen #(.IO_WAITS(4'd0)) u_c (
        .clock(clock), .reset(reset), .cpu_clock(cpu_clock), .address(address),
        .io_read_n(io_read_n), .io_write_n(io_write_n),
        .memory_read_n(memory_read_n), .memory_write_n(memory_write_n),
        .address_enable_n(address_enable_n),
        .io_channel_ready(rdy[2]), .wait_active(wact[2])
    );

    task automatic chk(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: remaining waits per instance plus "bus cycle in progress"
    int io_waits_m [3] = '{2, 15, 0};
    int rem [3];
    bit in_cyc [3];
    bit m_prev_cmd = 1'b1;
    bit m_prev_cc = 1'b0;

    always @(posedge clock or posedge reset) begin
        bit cmd, io, mem, pos, strt;
        int w;
        if (reset) begin
            m_prev_cmd = 1'b1;
            m_prev_cc  = 1'b0;
            for (int k = 0; k < 3; k++) begin
                rem[k]    = 0;
                in_cyc[k] = 1'b0;
            end
        end else begin
            io   = !io_read_n || !io_write_n;
            mem  = !memory_read_n || !memory_write_n;
            cmd  = io || mem;
            pos  = cpu_clock && !m_prev_cc;
            strt = cmd && !m_prev_cmd && !address_enable_n;
            for (int k = 0; k < 3; k++) begin
                w = 0;
                if (io && ((address & 20'h0FFF0) == 20'h00300))
                    w = io_waits_m[k];
                else if (mem && ((address & 20'hF0000) == 20'hC0000))
                    w = 1;
                if (rem[k] > 0) begin
                    if (!cmd) begin
                        rem[k]    = 0;
                        in_cyc[k] = 1'b0;
                    end else if (pos) begin
                        rem[k] = rem[k] - 1;
                    end
                end else if (in_cyc[k]) begin
                    if (!cmd) in_cyc[k] = 1'b0;
                end else if (strt) begin
                    rem[k]    = w;
                    in_cyc[k] = 1'b1;
                end
            end
            m_prev_cmd = cmd;
            m_prev_cc  = cpu_clock;
        end
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clock) begin
        if (run_chk) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("model_ready[%0d]", k), rdy[k], logic'(rem[k] == 0));
                chk($sformatf("model_wait_active[%0d]", k), wact[k], logic'(rem[k] != 0));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        #1 reset = 1'b1;
        run_chk = 1'b1;
        #1;
        chk("reset_ready_a", rdy[0], 1'b1);
        chk("reset_wait_active_a", wact[0], 1'b0);
        tick(); tick();
        reset = 1'b0;
        tick(); tick();

        // I/O read hit, 2 waits on default instance
        address = 20'h00308; io_read_n = 1'b0;
        tick();
        chk("io_rd_start_a", rdy[0], 1'b0);
        chk("io_rd_start_b", rdy[1], 1'b0);
        chk("io_rd_zero_wait_c", rdy[2], 1'b1);
        cpu_clock = 1'b1; tick();
        chk("io_rd_edge1_a", rdy[0], 1'b0);
        cpu_clock = 1'b0; tick(); tick();
        chk("io_rd_between_a", rdy[0], 1'b0);
        cpu_clock = 1'b1; tick();
        chk("io_rd_edge2_a", rdy[0], 1'b1);
        cpu_clock = 1'b0; tick();
        chk("io_rd_hold_a", rdy[0], 1'b1);
        chk("io_rd_still_wait_b", rdy[1], 1'b0);
        io_read_n = 1'b1; tick();
        chk("io_rd_abort_b", rdy[1], 1'b1);
        tick();

        // Memory read hit: one wait edge
        address = 20'hC1234; memory_read_n = 1'b0;
        tick();
        chk("mem_hit_start_a", rdy[0], 1'b0);
        chk("mem_hit_start_c", rdy[2], 1'b0);
        cpu_clock = 1'b1; tick();
        chk("mem_hit_done_a", rdy[0], 1'b1);
        cpu_clock = 1'b0; tick();
        memory_read_n = 1'b1; tick(); tick();

        // Memory read miss: no wait
        address = 20'hF0000; memory_read_n = 1'b0;
        tick();
        chk("mem_miss_a", rdy[0], 1'b1);
        cpu_clock = 1'b1; tick(); cpu_clock = 1'b0; tick();
        chk("mem_miss_later_a", rdy[0], 1'b1);
        memory_read_n = 1'b1; tick(); tick();

        // I/O read outside the window: no wait
        address = 20'h00400; io_read_n = 1'b0;
        tick();
        chk("io_miss_a", rdy[0], 1'b1);
        io_read_n = 1'b1; tick(); tick();

        // DMA cycle: start ignored, and no late start when bus returns to CPU
        address_enable_n = 1'b1; address = 20'h00308; io_write_n = 1'b0;
        tick();
        chk("dma_a", rdy[0], 1'b1);
        chk("dma_b", rdy[1], 1'b1);
        cpu_clock = 1'b1; tick(); cpu_clock = 1'b0; tick();
        address_enable_n = 1'b0; tick();
        chk("dma_no_late_start_a", rdy[0], 1'b1);
        io_write_n = 1'b1; tick(); tick();

        // IO_WAITS=15 aborted after 3 edges
        io_write_n = 1'b0;
        tick();
        chk("w15_start_b", rdy[1], 1'b0);
        for (int i = 0; i < 3; i++) begin
            cpu_clock = 1'b1; tick(); cpu_clock = 1'b0; tick();
        end
        chk("w15_mid_b", rdy[1], 1'b0);
        chk("w15_mid_a_hold", rdy[0], 1'b1);
        io_write_n = 1'b1; tick();
        chk("w15_abort_b", rdy[1], 1'b1);
        chk("w15_abort_wait_active_b", wact[1], 1'b0);
        tick();

        // I/O and memory both hit: I/O wait count wins
        address = 20'hC0308; io_read_n = 1'b0; memory_read_n = 1'b0;
        tick();
        chk("prio_start_a", rdy[0], 1'b0);
        chk("prio_io_zero_c", rdy[2], 1'b1);
        cpu_clock = 1'b1; tick();
        chk("prio_edge1_a", rdy[0], 1'b0);
        cpu_clock = 1'b0; tick();
        io_read_n = 1'b1; memory_read_n = 1'b1; tick(); tick();

        // Asynchronous reset mid-WAIT with counter 2, command held low
        address = 20'h00308; io_read_n = 1'b0;
        tick();
        chk("rst_pre_a", rdy[0], 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_ready_a", rdy[0], 1'b1);
        chk("rst_async_wait_active_a", wact[0], 1'b0);
        tick();
        reset = 1'b0;
        tick();
        cpu_clock = 1'b1; tick(); cpu_clock = 1'b0; tick();
        chk("rst_no_spurious_a", rdy[0], 1'b1);
        chk("rst_no_spurious_b", rdy[1], 1'b1);
        io_read_n = 1'b1; tick(); tick();

        // Back-to-back cycles with one clock of command high between
        io_read_n = 1'b0;
        tick();
        chk("b2b_first_a", rdy[0], 1'b0);
        chk("b2b_first_c", rdy[2], 1'b1);
        io_read_n = 1'b1; tick();
        chk("b2b_gap_a", rdy[0], 1'b1);
        io_read_n = 1'b0; tick();
        chk("b2b_second_a", rdy[0], 1'b0);
        chk("b2b_second_c", rdy[2], 1'b1);
        cpu_clock = 1'b1; tick(); cpu_clock = 1'b0; tick();
        cpu_clock = 1'b1; tick();
        chk("b2b_second_done_a", rdy[0], 1'b1);
        cpu_clock = 1'b0; io_read_n = 1'b1; tick(); tick();

        run_chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/io_channel_ready_gen.md
IO_CHANNEL_READY_GEN -- requirements
Module: io_channel_ready_gen

Interface
REQ-001 Parameter IO_BASE, default 16'h0300, I/O window base compared against address[15:0].
REQ-002 Parameter IO_MASK, default 16'hFFF0, I/O window mask; hit = (address[15:0] & IO_MASK) == (IO_BASE & IO_MASK).
REQ-003 Parameter IO_WAITS, default 4'd2, cpu_clock wait cycles for an I/O window hit.
REQ-004 Parameter MEM_BASE, default 20'hC0000, memory window base compared against address[19:0].
REQ-005 Parameter MEM_MASK, default 20'hF0000, memory window mask, same hit rule as I/O.
REQ-006 Parameter MEM_WAITS, default 4'd1, cpu_clock wait cycles for a memory window hit.
REQ-007 clock  in  1  system clock; all logic on posedge clock.
REQ-008 reset  in  1  asynchronous, active-high.
REQ-009 cpu_clock  in  1  CPU bus clock level, synchronous to clock, sampled for edges.
REQ-010 address  in  20  bus address, stable while a command is low.
REQ-011 io_read_n, io_write_n, memory_read_n, memory_write_n  in  1 each  active-low bus commands.
REQ-012 address_enable_n  in  1  low = CPU owns bus; high = DMA cycle.
REQ-013 io_channel_ready  out  1  high = ready; low = wait request to the READY logic.
REQ-014 wait_active  out  1  high while state is WAIT.

Function
REQ-015 cpu_clock_posedge SHALL be ~prev_cpu_clock & cpu_clock, prev_cpu_clock registered on clock.
REQ-016 command SHALL be the OR of the four active-low commands, inverted; io_cmd = ~io_read_n | ~io_write_n; prev_command registered on clock.
REQ-017 start SHALL be ~prev_command & command & ~address_enable_n; starts while address_enable_n = 1 SHALL be ignored.
REQ-018 On start, io_cmd with I/O hit SHALL select IO_WAITS; otherwise a memory command with memory hit SHALL select MEM_WAITS; otherwise no wait. I/O has priority if both commands are low.
REQ-019 States IDLE, WAIT, HOLD; encoded 2 bits.
REQ-020 IDLE: start with selected waits > 0 -> WAIT, 4-bit counter loaded with waits; start with waits = 0 or no hit -> HOLD.
REQ-021 WAIT: each cpu_clock_posedge decrements counter; posedge with counter = 1 -> HOLD.
REQ-022 WAIT: command deasserted (abort) -> IDLE on the same clock, overriding the counter.
REQ-023 HOLD: remain until command = 0, then -> IDLE; new start edges in HOLD are impossible and SHALL be ignored.
REQ-024 io_channel_ready SHALL be registered: 0 exactly while state = WAIT, 1 otherwise; it falls one clock after the start edge.
REQ-025 Wait length SHALL equal the selected count of cpu_clock rising edges after WAIT entry; maximum 15.
REQ-026 wait_active SHALL equal ~io_channel_ready at all times.

Reset
REQ-027 While reset = 1: state IDLE, counter 0, io_channel_ready 1, wait_active 0, prev_cpu_clock 0, prev_command 1 (no spurious start on release).
REQ-028 Reset asserted mid-WAIT SHALL release io_channel_ready to 1 immediately (asynchronously).

Structure
REQ-029 State encoding, counter width (4) and default window constants SHALL live in shared package kfpc_bus_pkg.
REQ-030 One sub-module, cpu_clock_edge_detect (registered prev, posedge/negedge outputs), SHALL be instantiated; the rest is flat.

Verification
REQ-031 I/O read at 16'h0308, IO_WAITS = 2, address_enable_n = 0 -> io_channel_ready low 1 clock after io_read_n falls, high after the 2nd cpu_clock posedge, then HOLD until io_read_n rises.
REQ-032 Memory read at 20'hC1234, MEM_WAITS = 1 -> exactly one cpu_clock posedge of wait; memory read at 20'hF0000 -> io_channel_ready stays 1.
REQ-033 I/O write at 16'h0308 with address_enable_n = 1 (DMA) -> io_channel_ready stays 1, state goes to neither WAIT nor HOLD.
REQ-034 IO_WAITS = 15, io_write_n rises after 3 cpu_clock posedges -> state IDLE, io_channel_ready 1 on the next clock.
REQ-035 Reset pulsed while in WAIT with counter = 2 -> io_channel_ready 1 immediately; after release with a command held low, no wait is generated.
REQ-036 IO_WAITS = 0 with I/O hit -> io_channel_ready never low; back-to-back cycles with 1 clock of command high between each both insert waits.
